secventiator_instr: RTL and testbench

- Multi-cycle instruction sequencer for the 8-bit RISC core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the PC-register write enable and gates the jump/branch strobes into the next-PC logic, so the PC updates exactly once per retired instruction.
- Handles instruction/data memory ready handshakes with a wait timeout, and provides halt and bus-error terminal states.

---
 rtl/secventiator_pkg.sv | 19 +
 rtl/secventiator_instr_contor_asteptare.sv | 29 ++
 rtl/secventiator_instr.sv | 139 +++++++++++++
 tb/tb_secventiator_instr.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/secventiator_pkg.sv
// Shared definitions for the instruction sequencer: state encoding and
// the default memory wait limit.
package secventiator_pkg;

    localparam int MAX_WAIT_DEF = 15;
    localparam int WAIT_W       = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        HALT    = 3'd6,
        ERROR   = 3'd7
    } state_t;

endpackage

// File: rtl/secventiator_instr_contor_asteptare.sv
// Wait counter for memory handshakes: clr reloads zero, en counts one
// not-ready cycle, tc flags that the tolerated wait has been used up.
module contor_asteptare
    import secventiator_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/secventiator_instr.sv
// Multi-cycle sequencer of the 8-bit RISC core: walks each instruction
// through fetch/decode/execute/mem/writeback and retires it exactly once.
module secventiator_instr
    import secventiator_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_jump,
    input  logic             is_branch,
    input  logic             is_halt,
    input  logic             writes_reg,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic             jump_en,
    output logic             branch_en,
    output logic [2:0]       state,
    output logic             halted,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count
);

    state_t state_q, state_d;
    logic   retire;
    logic   wait_en, wait_clr, wait_tc;
    logic   mem_op, store_op;

    // A load/store conflict from the decoder resolves to a load.
    assign mem_op   = is_load | is_store;
    assign store_op = is_store & ~is_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_we   = 1'b0;
        retire  = 1'b0;
        wait_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                // Ready on the terminal-count cycle still counts as success.
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end else if (wait_tc) begin
                    state_d = ERROR;
                end else begin
                    wait_en = 1'b1;
                end
            end
            DECODE: begin
                state_d = is_halt ? HALT : EXECUTE;
            end
            EXECUTE: begin
                if (mem_op) begin
                    state_d = MEM;
                end else if (writes_reg) begin
                    state_d = WB;
                end else begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            MEM: begin
                if (dmem_ready) begin
                    if (is_load) begin
                        state_d = WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                end else if (wait_tc) begin
                    state_d = ERROR;
                end else begin
                    wait_en = 1'b1;
                end
            end
            WB: begin
                retire  = 1'b1;
                state_d = FETCH;
            end
            HALT:  state_d = HALT;
            ERROR: state_d = ERROR;
        endcase
    end

    // Any state change restarts the wait budget, so each FETCH/MEM entry starts at zero.
    assign wait_clr = (state_d != state_q);

    contor_asteptare #(
        .MAX_WAIT(MAX_WAIT)
    ) u_contor (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (wait_clr),
        .en   (wait_en),
        .tc   (wait_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + 1'b1;
        end
    end

    assign imem_req  = (state_q == FETCH);
    assign dmem_req  = (state_q == MEM);
    assign dmem_we   = (state_q == MEM) & store_op;
    assign reg_we    = (state_q == WB);
    assign halted    = (state_q == HALT);
    assign bus_error = (state_q == ERROR);
    assign pc_we     = retire;
    assign jump_en   = retire & is_jump;
    assign branch_en = retire & is_branch;
    assign state     = state_q;

endmodule

// File: tb/tb_secventiator_instr.sv
// Scoreboard bench for secventiator_instr: the driver predicts each cycle's
// outputs from the instruction-level rules, the monitor compares at negedge.
module tb_secventiator_instr;

  localparam int MW = 15;
  localparam bit O  = 1'b0;
  localparam bit I  = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n, start, imem_ready, dmem_ready;
  logic       is_load, is_store, is_jump, is_branch, is_halt, writes_reg;
  logic       imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, jump_en, branch_en;
  logic [2:0] state;
  logic       halted, bus_error;
  logic [7:0] instr_count;

  secventiator_instr #(.MAX_WAIT(MW), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .is_load(is_load), .is_store(is_store), .is_jump(is_jump),
    .is_branch(is_branch), .is_halt(is_halt), .writes_reg(writes_reg),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_we(reg_we), .pc_we(pc_we), .jump_en(jump_en), .branch_en(branch_en),
    .state(state), .halted(halted), .bus_error(bus_error),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [20:0] exp_q[$];
  logic [20:0] act, mon_e;
  logic [7:0]  cnt;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  assign act = {state, imem_req, ir_we, dmem_req, dmem_we, reg_we,
                pc_we, jump_en, branch_en, halted, bus_error, instr_count};

  function automatic logic [20:0] mk(input logic [2:0] st, input bit imr, input bit irw,
                                     input bit dr, input bit dw, input bit rw, input bit pw,
                                     input bit je, input bit be, input bit h, input bit er,
                                     input logic [7:0] c);
    return {st, imr, irw, dr, dw, rw, pw, je, be, h, er, c};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        if (act !== mon_e) begin
          errors++;
          $display("FAIL cycle%0d {state,imem_req,ir_we,dmem_req,dmem_we,reg_we,pc_we,jump_en,branch_en,halted,bus_error,count} got=%b want=%b",
                   cyc, act, mon_e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic [20:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    start      = 1'($urandom);
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    is_load    = 1'($urandom);
    is_store   = 1'($urandom);
    is_jump    = 1'($urandom);
    is_branch  = 1'($urandom);
    is_halt    = 1'($urandom);
    writes_reg = 1'($urandom);
  endtask

  // kind: 0 ALU writing a register, 1 no register write (jump/branch/nop), 2 load, 3 store, 4 halt
  task automatic set_dec(input int kind, input bit j, input bit b, input bit conf);
    is_load    = (kind == 2);
    is_store   = (kind == 3) || (kind == 2 && conf);
    is_jump    = j;
    is_branch  = b;
    is_halt    = (kind == 4);
    writes_reg = (kind == 0 || kind == 2) ? 1'b1 : (kind == 1 ? 1'b0 : 1'($urandom));
  endtask

  task automatic do_instr(input int kind, input int fw, input int mw, input bit j, input bit b,
                          input bit conf, input int abort, output int res);
    bit st_op, rdy, ret;
    st_op = (kind == 3);
    res   = 0;
    for (int k = 0; k <= MW; k++) begin
      noise();
      rdy = (k == fw);
      imem_ready = rdy;
      step(mk(3'd1, I, rdy, O, O, O, O, O, O, O, O, cnt));
      if (rdy) break;
    end
    if (fw > MW) begin
      res = 1;
      return;
    end
    noise(); set_dec(kind, j, b, conf);
    step(mk(3'd2, O, O, O, O, O, O, O, O, O, O, cnt));
    if (kind == 4) begin
      res = 2;
      return;
    end
    noise(); set_dec(kind, j, b, conf);
    if (kind == 1) begin
      step(mk(3'd3, O, O, O, O, O, I, j, b, O, O, cnt));
      cnt = cnt + 8'd1;
      return;
    end
    step(mk(3'd3, O, O, O, O, O, O, O, O, O, O, cnt));
    if (kind >= 2) begin
      for (int k = 0; k <= MW; k++) begin
        if (k == abort) begin
          res = 3;
          return;
        end
        noise(); set_dec(kind, j, b, conf);
        rdy = (k == mw);
        dmem_ready = rdy;
        ret = rdy && st_op;
        step(mk(3'd4, O, O, I, st_op, O, ret, ret & j, ret & b, O, O, cnt));
        if (ret) cnt = cnt + 8'd1;
        if (rdy) break;
      end
      if (mw > MW) begin
        res = 1;
        return;
      end
      if (st_op) return;
    end
    noise(); set_dec(kind, j, b, conf);
    step(mk(3'd5, O, O, O, O, I, I, j, b, O, O, cnt));
    cnt = cnt + 8'd1;
  endtask

  task automatic linger(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      noise();
      step(mk(st, O, O, O, O, O, O, O, O, st == 3'd6, st == 3'd7, cnt));
    end
  endtask

  // Reset is asserted mid-cycle; the monitor sees its effect before any rising edge.
  task automatic do_reset();
    noise();
    rst_n = 1'b0;
    cnt   = 8'd0;
    step(mk(3'd0, O, O, O, O, O, O, O, O, O, O, cnt));
    noise();
    step(mk(3'd0, O, O, O, O, O, O, O, O, O, O, cnt));
    rst_n = 1'b1;
  endtask

  task automatic begin_run(input int idle);
    for (int i = 0; i < idle; i++) begin
      noise(); start = 1'b0;
      step(mk(3'd0, O, O, O, O, O, O, O, O, O, O, cnt));
    end
    noise(); start = 1'b1;
    step(mk(3'd0, O, O, O, O, O, O, O, O, O, O, cnt));
  endtask

  function automatic int pick_wait();
    return ($urandom_range(7, 0) == 0) ? MW : int'($urandom_range(3, 0));
  endfunction

  int res;

  initial begin
    rst_n = 1'b0; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    is_load = 1'b0; is_store = 1'b0; is_jump = 1'b0; is_branch = 1'b0;
    is_halt = 1'b0; writes_reg = 1'b0; cnt = 8'd0;
    @(posedge clk); #1;
    do_reset();
    begin_run(2);

    do_instr(0, 0, 0, 1'b0, 1'b0, 1'b0, -1, res);
    checks++;
    if (instr_count !== 8'd1) begin
      errors++;
      $display("FAIL alu retire instr_count got=%0d want=1", instr_count);
    end
    do_instr(1, 0, 0, 1'b1, 1'b0, 1'b0, -1, res);
    do_instr(1, 1, 0, 1'b0, 1'b1, 1'b0, -1, res);
    do_instr(3, 0, 3, 1'b0, 1'b0, 1'b0, -1, res);
    do_instr(2, 0, 2, 1'b0, 1'b0, 1'b0, -1, res);
    do_instr(2, 2, 1, 1'b1, 1'b0, 1'b1, -1, res);
    do_instr(0, MW, 0, 1'b0, 1'b0, 1'b0, -1, res);
    do_instr(3, 0, MW, 1'b1, 1'b1, 1'b0, -1, res);

    for (int n = 0; n < 300; n++) begin
      do_instr(int'($urandom_range(3, 0)), pick_wait(), pick_wait(),
               1'($urandom), 1'($urandom), 1'($urandom), -1, res);
    end

    do_instr(0, MW + 1, 0, 1'b0, 1'b0, 1'b0, -1, res);
    linger(3'd7, 5);
    checks++;
    if (bus_error !== 1'b1) begin
      errors++;
      $display("FAIL timeout bus_error got=%b want=1", bus_error);
    end
    checks++;
    if (state !== 3'd7) begin
      errors++;
      $display("FAIL timeout state got=%0d want=7", state);
    end
    do_reset(); begin_run(1);

    do_instr(1, 0, 0, 1'b1, 1'b1, 1'b0, -1, res);
    do_instr(2, 0, MW + 1, 1'b0, 1'b0, 1'b0, -1, res);
    linger(3'd7, 4);
    do_reset(); begin_run(0);

    do_instr(0, 0, 0, 1'b0, 1'b0, 1'b0, -1, res);
    do_instr(4, 2, 0, 1'b1, 1'b1, 1'b0, -1, res);
    linger(3'd6, 8);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halt halted got=%b want=1", halted);
    end
    checks++;
    if (pc_we !== 1'b0) begin
      errors++;
      $display("FAIL halt pc_we got=%b want=0", pc_we);
    end
    checks++;
    if (instr_count !== cnt) begin
      errors++;
      $display("FAIL halt instr_count got=%0d want=%0d", instr_count, cnt);
    end
    do_reset(); begin_run(1);

    do_instr(3, 0, MW, 1'b0, 1'b0, 1'b0, 2, res);
    do_reset(); begin_run(1);

    for (int n = 0; n < 256; n++) begin
      do_instr(1, 0, 0, 1'($urandom), 1'($urandom), 1'b0, -1, res);
    end
    do_instr(0, 0, 0, 1'b0, 1'b0, 1'b0, -1, res);
    checks++;
    if (instr_count !== cnt) begin
      errors++;
      $display("FAIL wrap instr_count got=%0d want=%0d", instr_count, cnt);
    end

    @(negedge clk);
    if (checks <= 0) begin
      errors++;
      $display("FAIL no checks got=%0d want=>0", checks);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
